mouse_sequencer: RTL and testbench

MOUSE_SEQUENCER -- requirements
Module: MOUSE_SEQUENCER

---
 rtl/mouse_sequencer_if.sv | 30 +++
 rtl/mouse_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mouse_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mouse_sequencer_if.sv
// Handshake bundle between the mouse sequencer, the PS/2 controller and the
// packet consumer. master is the sequencer side; slave is its environment.
interface mouse_sequencer_if;
  logic       start;
  logic [7:0] ps2_cmd;
  logic       ps2_send;
  logic       ps2_cmd_sent;
  logic       ps2_timeout;
  logic [7:0] ps2_data;
  logic       ps2_data_en;
  logic       pkt_valid;
  logic [2:0] pkt_buttons;
  logic [8:0] pkt_dx;
  logic [8:0] pkt_dy;
  logic       pkt_overflow;
  logic       ready;
  logic       error;

  modport master (
    input  start, ps2_cmd_sent, ps2_timeout, ps2_data, ps2_data_en,
    output ps2_cmd, ps2_send, pkt_valid, pkt_buttons, pkt_dx, pkt_dy,
           pkt_overflow, ready, error
  );

  modport slave (
    output start, ps2_cmd_sent, ps2_timeout, ps2_data, ps2_data_en,
    input  ps2_cmd, ps2_send, pkt_valid, pkt_buttons, pkt_dx, pkt_dy,
           pkt_overflow, ready, error
  );
endinterface

// File: rtl/mouse_sequencer.sv
// PS/2 mouse bring-up (reset, BAT, ID, enable reporting) with bounded retries,
// followed by 3-byte stream packet assembly.
module mouse_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic              clk,
  input  logic              reset,
  mouse_sequencer_if.master bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RW = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

  typedef enum logic [3:0] {
    IDLE, SEND_RST, WAIT_ACK_RST, WAIT_BAT, WAIT_ID,
    SEND_EN, WAIT_ACK_EN, STREAM, ERROR
  } state_t;

  state_t        state_q, state_d, wait_next;
  logic [RW-1:0] retry_q, retry_d, retry_inc;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    b0_q, b0_d, b1_q, b1_d;
  logic [7:0]    ps2_cmd_q, ps2_cmd_d, expected;
  logic          ps2_send_q, ps2_send_d;
  logic          pkt_valid_q, pkt_valid_d, pkt_overflow_q, pkt_overflow_d;
  logic [2:0]    pkt_buttons_q, pkt_buttons_d;
  logic [8:0]    pkt_dx_q, pkt_dx_d, pkt_dy_q, pkt_dy_d;
  logic          ready_q, ready_d, error_q, error_d;
  logic          fail, expired;

  always_comb begin
    expected  = 8'hFA;
    wait_next = WAIT_BAT;
    case (state_q)
      WAIT_BAT:    begin expected = 8'hAA; wait_next = WAIT_ID; end
      WAIT_ID:     begin expected = 8'h00; wait_next = SEND_EN; end
      WAIT_ACK_EN: begin expected = 8'hFA; wait_next = STREAM;  end
      default:     begin expected = 8'hFA; wait_next = WAIT_BAT; end
    endcase
  end

  assign expired   = (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign retry_inc = retry_q + RW'(1);

  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    timer_d       = '0;
    idx_d         = idx_q;
    b0_d          = b0_q;
    b1_d          = b1_q;
    pkt_buttons_d = pkt_buttons_q;
    pkt_dx_d      = pkt_dx_q;
    pkt_dy_d      = pkt_dy_q;
    pkt_valid_d   = 1'b0;
    pkt_overflow_d = 1'b0;
    fail          = 1'b0;

    case (state_q)
      IDLE, ERROR: if (bus.start) begin
        state_d = SEND_RST;
        retry_d = '0;
      end
      SEND_RST, SEND_EN: begin
        if (bus.ps2_cmd_sent) state_d = (state_q == SEND_RST) ? WAIT_ACK_RST : WAIT_ACK_EN;
        else if (bus.ps2_timeout) fail = 1'b1;
      end
      WAIT_ACK_RST, WAIT_BAT, WAIT_ID, WAIT_ACK_EN: begin
        if (bus.ps2_data_en) begin
          if (bus.ps2_data == expected) state_d = wait_next;
          else fail = 1'b1;
        end else if (expired) fail = 1'b1;
        else timer_d = timer_q + TW'(1);
      end
      STREAM: begin
        if (bus.start) begin
          state_d = SEND_RST;
          retry_d = '0;
        end else if (bus.ps2_data_en) begin
          case (idx_q)
            2'd0: if (bus.ps2_data[3]) begin
              b0_d  = bus.ps2_data;
              idx_d = 2'd1;
            end
            2'd1: begin
              b1_d  = bus.ps2_data;
              idx_d = 2'd2;
            end
            default: begin
              idx_d = 2'd0;
              if (b0_q[7] || b0_q[6]) pkt_overflow_d = 1'b1;
              else begin
                pkt_valid_d   = 1'b1;
                pkt_buttons_d = b0_q[2:0];
                pkt_dx_d      = {b0_q[4], b1_q};
                pkt_dy_d      = {b0_q[5], bus.ps2_data};
              end
            end
          endcase
        end else if (idx_q != 2'd0) begin
          // A stalled partial packet is abandoned silently to resync.
          if (expired) idx_d = 2'd0;
          else timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (fail) begin
      retry_d = retry_inc;
      state_d = (retry_inc == RW'(MAX_RETRIES)) ? ERROR : SEND_RST;
    end
    if (state_d != STREAM) idx_d = 2'd0;

    // Outputs are registered from the next state so they track the state register.
    ps2_send_d = (state_d == SEND_RST) || (state_d == SEND_EN);
    ps2_cmd_d  = (state_d == SEND_RST) ? 8'hFF :
                 (state_d == SEND_EN)  ? 8'hF4 : ps2_cmd_q;
    ready_d    = (state_d == STREAM);
    error_d    = (state_d == ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      retry_q        <= '0;
      timer_q        <= '0;
      idx_q          <= '0;
      b0_q           <= '0;
      b1_q           <= '0;
      ps2_cmd_q      <= '0;
      ps2_send_q     <= 1'b0;
      pkt_valid_q    <= 1'b0;
      pkt_overflow_q <= 1'b0;
      pkt_buttons_q  <= '0;
      pkt_dx_q       <= '0;
      pkt_dy_q       <= '0;
      ready_q        <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      retry_q        <= retry_d;
      timer_q        <= timer_d;
      idx_q          <= idx_d;
      b0_q           <= b0_d;
      b1_q           <= b1_d;
      ps2_cmd_q      <= ps2_cmd_d;
      ps2_send_q     <= ps2_send_d;
      pkt_valid_q    <= pkt_valid_d;
      pkt_overflow_q <= pkt_overflow_d;
      pkt_buttons_q  <= pkt_buttons_d;
      pkt_dx_q       <= pkt_dx_d;
      pkt_dy_q       <= pkt_dy_d;
      ready_q        <= ready_d;
      error_q        <= error_d;
    end
  end

  assign bus.ps2_cmd      = ps2_cmd_q;
  assign bus.ps2_send     = ps2_send_q;
  assign bus.pkt_valid    = pkt_valid_q;
  assign bus.pkt_overflow = pkt_overflow_q;
  assign bus.pkt_buttons  = pkt_buttons_q;
  assign bus.pkt_dx       = pkt_dx_q;
  assign bus.pkt_dy       = pkt_dy_q;
  assign bus.ready        = ready_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_mouse_sequencer.sv
// Directed bench for mouse_sequencer: init handshake, packet table, resync,
// partial-packet timeout, retries/ERROR, and asynchronous reset.
module tb_mouse_sequencer;

  localparam int unsigned TO = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mouse_sequencer_if bus();

  mouse_sequencer #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic       valid, ovf;
    logic [2:0] btn;
    logic [8:0] dx, dy;
  } pkt_vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.ps2_data    = b;
    bus.ps2_data_en = 1'b1;
    tick();
    bus.ps2_data_en = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_send(input string name, input logic [7:0] cmd);
    int n = 0;
    while (bus.ps2_send !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_send"}, 32'(bus.ps2_send), 1);
    chk({name, "_cmd"}, 32'(bus.ps2_cmd), 32'(cmd));
  endtask

  task automatic accept();
    bus.ps2_cmd_sent = 1'b1;
    tick();
    bus.ps2_cmd_sent = 1'b0;
  endtask

  task automatic do_init(input string name);
    pulse_start();
    wait_send({name, "_rst"}, 8'hFF);
    accept();
    chk({name, "_send_low"}, 32'(bus.ps2_send), 0);
    send_byte(8'hFA);
    send_byte(8'hAA);
    send_byte(8'h00);
    wait_send({name, "_en"}, 8'hF4);
    accept();
    chk({name, "_ready_early"}, 32'(bus.ready), 0);
    send_byte(8'hFA);
    chk({name, "_ready"}, 32'(bus.ready), 1);
  endtask

  task automatic chk_pkt(input string name, input logic [2:0] btn,
                         input logic [8:0] dx, input logic [8:0] dy);
    chk({name, "_btn"}, 32'(bus.pkt_buttons), 32'(btn));
    chk({name, "_dx"}, 32'(bus.pkt_dx), 32'(dx));
    chk({name, "_dy"}, 32'(bus.pkt_dy), 32'(dy));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_vec_t vec[6];
    int n;

    // b0=09 has bit5 clear, so dy decodes as +254; b0=29 gives the -2 case.
    vec[0] = '{b0:8'h09, b1:8'h05, b2:8'hFE, valid:1, ovf:0, btn:3'b001, dx:9'h005, dy:9'h0FE};
    vec[1] = '{b0:8'h29, b1:8'h05, b2:8'hFE, valid:1, ovf:0, btn:3'b001, dx:9'h005, dy:9'h1FE};
    vec[2] = '{b0:8'h48, b1:8'h01, b2:8'h01, valid:0, ovf:1, btn:3'b001, dx:9'h005, dy:9'h1FE};
    vec[3] = '{b0:8'h3B, b1:8'hFF, b2:8'h80, valid:1, ovf:0, btn:3'b011, dx:9'h1FF, dy:9'h180};
    vec[4] = '{b0:8'h88, b1:8'h02, b2:8'h03, valid:0, ovf:1, btn:3'b011, dx:9'h1FF, dy:9'h180};
    vec[5] = '{b0:8'h1C, b1:8'h03, b2:8'h04, valid:1, ovf:0, btn:3'b100, dx:9'h103, dy:9'h004};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.ps2_cmd_sent = 1'b0;
    bus.ps2_timeout = 1'b0;
    bus.ps2_data = 8'h00;
    bus.ps2_data_en = 1'b0;
    tick();
    tick();
    chk("rst_send", 32'(bus.ps2_send), 0);
    chk("rst_cmd", 32'(bus.ps2_cmd), 0);
    chk("rst_valid", 32'(bus.pkt_valid), 0);
    chk("rst_ovf", 32'(bus.pkt_overflow), 0);
    chk_pkt("rst_pkt", 3'b000, 9'h000, 9'h000);
    chk("rst_ready", 32'(bus.ready), 0);
    chk("rst_error", 32'(bus.error), 0);
    reset = 1'b0;
    tick();

    do_init("init");

    foreach (vec[i]) begin
      send_byte(vec[i].b0);
      send_byte(vec[i].b1);
      chk($sformatf("vec%0d_mid_valid", i), 32'(bus.pkt_valid), 0);
      send_byte(vec[i].b2);
      chk($sformatf("vec%0d_valid", i), 32'(bus.pkt_valid), 32'(vec[i].valid));
      chk($sformatf("vec%0d_ovf", i), 32'(bus.pkt_overflow), 32'(vec[i].ovf));
      chk_pkt($sformatf("vec%0d", i), vec[i].btn, vec[i].dx, vec[i].dy);
      tick();
      chk($sformatf("vec%0d_valid_end", i), 32'(bus.pkt_valid), 0);
      chk($sformatf("vec%0d_ovf_end", i), 32'(bus.pkt_overflow), 0);
    end

    // Byte 0 without bit3 is discarded.
    send_byte(8'h01);
    send_byte(8'h08);
    send_byte(8'h10);
    chk("resync_mid_valid", 32'(bus.pkt_valid), 0);
    send_byte(8'h20);
    chk("resync_valid", 32'(bus.pkt_valid), 1);
    chk_pkt("resync", 3'b000, 9'h010, 9'h020);

    // Gap shorter than the timeout keeps the partial packet.
    send_byte(8'h0A);
    repeat (TO - 10) tick();
    send_byte(8'h0B);
    send_byte(8'h0C);
    chk("short_gap_valid", 32'(bus.pkt_valid), 1);
    chk_pkt("short_gap", 3'b010, 9'h00B, 9'h00C);

    // Stalled partial packet is dropped after the timeout.
    send_byte(8'h08);
    repeat (TO + 5) tick();
    send_byte(8'h09);
    send_byte(8'h05);
    chk("stall_mid_valid", 32'(bus.pkt_valid), 0);
    send_byte(8'hFE);
    chk("stall_valid", 32'(bus.pkt_valid), 1);
    chk_pkt("stall", 3'b001, 9'h005, 9'h0FE);
    chk("stall_ready", 32'(bus.ready), 1);
    chk("stall_error", 32'(bus.error), 0);

    // start in STREAM discards a partial packet.
    send_byte(8'h08);
    send_byte(8'h10);
    do_init("reinit");
    send_byte(8'h09);
    chk("discard_valid0", 32'(bus.pkt_valid), 0);
    send_byte(8'h07);
    send_byte(8'h03);
    chk("discard_valid", 32'(bus.pkt_valid), 1);
    chk_pkt("discard", 3'b001, 9'h007, 9'h003);

    // No responses: three resets, each waiting the full timeout, then ERROR.
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      wait_send($sformatf("retry%0d", k), 8'hFF);
      accept();
      n = 0;
      while (bus.ps2_send !== 1'b1 && bus.error !== 1'b1 && n < 300) begin
        tick();
        n++;
      end
      chk($sformatf("retry%0d_gap", k), n, TO);
      chk($sformatf("retry%0d_error", k), 32'(bus.error), (k == 2) ? 1 : 0);
    end
    chk("err_send", 32'(bus.ps2_send), 0);
    chk("err_ready", 32'(bus.ready), 0);
    repeat (20) tick();
    chk("err_persist", 32'(bus.error), 1);

    // Controller timeouts count as failures too.
    pulse_start();
    chk("tmo_leave_error", 32'(bus.error), 0);
    bus.ps2_timeout = 1'b1;
    tick();
    tick();
    chk("tmo_send2", 32'(bus.ps2_send), 1);
    chk("tmo_error2", 32'(bus.error), 0);
    tick();
    bus.ps2_timeout = 1'b0;
    chk("tmo_error3", 32'(bus.error), 1);
    chk("tmo_send3", 32'(bus.ps2_send), 0);

    // cmd_sent and timeout together: cmd_sent wins.
    pulse_start();
    bus.ps2_cmd_sent = 1'b1;
    bus.ps2_timeout = 1'b1;
    tick();
    bus.ps2_cmd_sent = 1'b0;
    bus.ps2_timeout = 1'b0;
    chk("both_send", 32'(bus.ps2_send), 0);
    chk("both_error", 32'(bus.error), 0);
    send_byte(8'hFA);
    send_byte(8'hAA);
    send_byte(8'h00);
    wait_send("both_en", 8'hF4);
    accept();
    send_byte(8'hFA);
    chk("both_ready", 32'(bus.ready), 1);

    // FC in WAIT_BAT retries; start inside a WAIT state is ignored.
    pulse_start();
    wait_send("fc_rst", 8'hFF);
    accept();
    send_byte(8'hFA);
    pulse_start();
    chk("fc_start_ignored", 32'(bus.ps2_send), 0);
    send_byte(8'hFC);
    chk("fc_retry_send", 32'(bus.ps2_send), 1);
    chk("fc_retry_cmd", 32'(bus.ps2_cmd), 8'hFF);
    accept();
    send_byte(8'hFA);
    send_byte(8'hAA);
    send_byte(8'h00);
    wait_send("fc_en", 8'hF4);
    accept();
    send_byte(8'hFA);
    chk("fc_ready", 32'(bus.ready), 1);

    // Asynchronous reset while a command is being sent.
    pulse_start();
    chk("arst_pre_send", 32'(bus.ps2_send), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_send", 32'(bus.ps2_send), 0);
    chk("arst_cmd", 32'(bus.ps2_cmd), 0);
    chk_pkt("arst_pkt", 3'b000, 9'h000, 9'h000);
    tick();
    reset = 1'b0;
    tick();
    send_byte(8'h09);
    send_byte(8'h05);
    send_byte(8'hFE);
    chk("arst_idle_valid", 32'(bus.pkt_valid), 0);
    chk("arst_idle_ready", 32'(bus.ready), 0);
    chk("arst_idle_send", 32'(bus.ps2_send), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
